// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package riscv_types;

  // Loader sequencing: wait for start, collect bytes, emit one word, signal completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  localparam int LOADER_BYTE_W = 8;

  // Width of a byte-lane index; a single-byte word still needs a 1-bit counter.
  function automatic int loader_idx_w(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - little-endian byte-to-word packing register
module word_assembler
  import riscv_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [LOADER_BYTE_W-1:0] byte_in,
  input  logic                     accept_in,
  input  logic                     clear_in,
  output logic [WIDTH-1:0]         word_out,
  output logic                     last_byte_out
);

  localparam int BYTES = WIDTH / LOADER_BYTE_W;
  localparam int IDX_W = loader_idx_w(BYTES);

  logic [IDX_W-1:0] byte_idx;

  // The lane about to be filled is the final one of the word.
  assign last_byte_out = (byte_idx == IDX_W'(BYTES - 1));

  // Place each accepted byte in its lane; clear discards any partial word.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      byte_idx <= '0;
      word_out <= '0;
    end else if (clear_in) begin
      byte_idx <= '0;
      word_out <= '0;
    end else if (accept_in) begin
      for (int i = 0; i < BYTES; i++) begin
        if (byte_idx == IDX_W'(i)) begin
          word_out[LOADER_BYTE_W*i +: LOADER_BYTE_W] <= byte_in;
        end
      end
      byte_idx <= last_byte_out ? '0 : byte_idx + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a byte program into instruction memory while holding the core
module imem_loader
  import riscv_types::*;
#(
  parameter int WIDTH = 32,
  parameter int INDEX = 6
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  input  logic [INDEX:0]           word_count_in,
  input  logic                     byte_valid_in,
  input  logic [LOADER_BYTE_W-1:0] byte_in,
  output logic                     byte_ready_out,
  output logic                     imem_we_out,
  output logic [INDEX-1:0]         imem_addr_out,
  output logic [WIDTH-1:0]         imem_data_out,
  output logic                     core_hold_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic [WIDTH-1:0]         checksum_out
);

  loader_state_t    state;
  loader_state_t    state_nxt;
  logic [INDEX:0]   word_cnt;
  logic [INDEX:0]   words_done;
  logic             accept;
  logic             asm_clear;
  logic             last_byte;
  logic             last_word;
  logic [WIDTH-1:0] word;

  // Acceptance is derived from state rather than from byte_ready_out so the
  // next-state logic has no path through its own outputs.
  assign accept    = byte_valid_in && (state == RECV);
  // Counters are INDEX+1 bits so a full-depth load (count = 2**INDEX) compares exactly.
  assign last_word = ((words_done + 1'b1) == word_cnt);

  word_assembler #(
    .WIDTH(WIDTH)
  ) u_word_assembler (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .byte_in       (byte_in),
    .accept_in     (accept),
    .clear_in      (asm_clear),
    .word_out      (word),
    .last_byte_out (last_byte)
  );

  // The assembled word is registered inside the assembler, so it drives imem directly.
  assign imem_data_out = word;

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection and state-decoded outputs.
  always_comb begin
    state_nxt      = state;
    byte_ready_out = 1'b0;
    imem_we_out    = 1'b0;
    core_hold_out  = 1'b0;
    busy_out       = 1'b0;
    done_out       = 1'b0;
    asm_clear      = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) begin
          asm_clear = 1'b1;
          state_nxt = (word_count_in == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        byte_ready_out = 1'b1;
        core_hold_out  = 1'b1;
        busy_out       = 1'b1;
        if (accept && last_byte) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        imem_we_out   = 1'b1;
        core_hold_out = 1'b1;
        busy_out      = 1'b1;
        asm_clear     = 1'b1;
        state_nxt     = last_word ? DONE : RECV;
      end
      DONE: begin
        done_out      = 1'b1;
        core_hold_out = 1'b1;
        busy_out      = 1'b1;
        state_nxt     = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Load bookkeeping: latched count, written-word count, address and running checksum.
  // The address only advances when another word follows, so a full-depth load
  // finishes on the top address instead of wrapping to 0.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      word_cnt      <= '0;
      words_done    <= '0;
      imem_addr_out <= '0;
      checksum_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            word_cnt      <= word_count_in;
            words_done    <= '0;
            imem_addr_out <= '0;
            checksum_out  <= '0;
          end
        end
        WRITE: begin
          checksum_out <= checksum_out + word;
          words_done   <= words_done + 1'b1;
          if (!last_word) begin
            imem_addr_out <= imem_addr_out + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for the instruction-memory loader
module tb_imem_loader;

  localparam int WIDTH = 32;
  localparam int INDEX = 6;

  typedef struct packed {
    logic [INDEX-1:0] addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [INDEX:0]   word_count = '0;
  logic             byte_valid = 1'b0;
  logic [7:0]       byte_data = '0;
  logic             byte_ready_out;
  logic             imem_we_out;
  logic [INDEX-1:0] imem_addr_out;
  logic [WIDTH-1:0] imem_data_out;
  logic             core_hold_out;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] checksum_out;

  wr_t sb_q[$];
  int  n_tests  = 0;
  int  n_fail   = 0;
  int  we_total = 0;
  int  we_mark  = 0;
  logic prev_we = 1'b0;

  imem_loader #(
    .WIDTH(WIDTH),
    .INDEX(INDEX)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .start_in       (start),
    .word_count_in  (word_count),
    .byte_valid_in  (byte_valid),
    .byte_in        (byte_data),
    .byte_ready_out (byte_ready_out),
    .imem_we_out    (imem_we_out),
    .imem_addr_out  (imem_addr_out),
    .imem_data_out  (imem_data_out),
    .core_hold_out  (core_hold_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .checksum_out   (checksum_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write and last one cycle.
  always @(negedge clk) begin
    if (!rst && imem_we_out) begin
      wr_t e;
      we_total++;
      check_val("we_single_cycle", {63'd0, prev_we}, 64'd0);
      if (sb_q.size() == 0) begin
        check_val("we_unexpected", {63'd0, imem_we_out}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("wr_addr", {58'd0, imem_addr_out}, {58'd0, e.addr});
        check_val("wr_data", {32'd0, imem_data_out}, {32'd0, e.data});
      end
    end
    prev_we = imem_we_out;
  end

  task automatic do_start(input int cnt);
    start = 1'b1;
    word_count = (INDEX+1)'(cnt);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; ready is state-decoded, so its
  // negedge value is what the next rising edge sees.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic got;
    got = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data = b;
    for (int n = 0; n < 200 && !got; n++) begin
      got = byte_ready_out;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    if (!got) check_val("byte_timeout", {63'd0, byte_ready_out}, 64'd1);
  endtask

  task automatic send_word(input int addr, input logic [WIDTH-1:0] w, input int gap);
    wr_t e;
    e.addr = INDEX'(addr);
    e.data = w;
    sb_q.push_back(e);
    for (int i = 0; i < WIDTH/8; i++) send_byte(w[8*i +: 8], gap);
    check_val("we_after_last_byte", {63'd0, imem_we_out}, 64'd1);
    check_val("ready_low_in_write", {63'd0, byte_ready_out}, 64'd0);
  endtask

  task automatic wait_done(input logic [WIDTH-1:0] exp_sum, input string tag);
    int n;
    n = 0;
    while (!done_out && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_done"}, {63'd0, done_out}, 64'd1);
    check_val({tag, "_sum"}, {32'd0, checksum_out}, {32'd0, exp_sum});
    check_val({tag, "_hold_in_done"}, {63'd0, core_hold_out}, 64'd1);
    @(negedge clk);
    check_val({tag, "_done_pulse"}, {63'd0, done_out}, 64'd0);
    check_val({tag, "_busy_idle"}, {63'd0, busy_out}, 64'd0);
    check_val({tag, "_hold_idle"}, {63'd0, core_hold_out}, 64'd0);
    check_val({tag, "_sum_hold"}, {32'd0, checksum_out}, {32'd0, exp_sum});
    check_val({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ready"}, {63'd0, byte_ready_out}, 64'd0);
    check_val({tag, "_we"}, {63'd0, imem_we_out}, 64'd0);
    check_val({tag, "_addr"}, {58'd0, imem_addr_out}, 64'd0);
    check_val({tag, "_data"}, {32'd0, imem_data_out}, 64'd0);
    check_val({tag, "_hold"}, {63'd0, core_hold_out}, 64'd0);
    check_val({tag, "_busy"}, {63'd0, busy_out}, 64'd0);
    check_val({tag, "_done"}, {63'd0, done_out}, 64'd0);
    check_val({tag, "_sum"}, {32'd0, checksum_out}, 64'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back bytes, two words.
    we_mark = we_total;
    do_start(2);
    send_word(0, 32'h0000_0013, 0);
    send_word(1, 32'h0010_0093, 0);
    wait_done(32'h0010_00A6, "t1");
    check_val("t1_we_count", 64'(we_total - we_mark), 64'd2);

    // Same stream with valid toggling every other cycle.
    we_mark = we_total;
    do_start(2);
    send_word(0, 32'h0000_0013, 1);
    send_word(1, 32'h0010_0093, 1);
    wait_done(32'h0010_00A6, "t2");
    check_val("t2_we_count", 64'(we_total - we_mark), 64'd2);

    // Empty load goes straight to DONE and clears the checksum.
    we_mark = we_total;
    do_start(0);
    check_val("t3_done_next", {63'd0, done_out}, 64'd1);
    wait_done(32'h0, "t3");
    check_val("t3_we_count", 64'(we_total - we_mark), 64'd0);

    // Full depth: word k = k, last write at the top address, no wrap.
    we_mark = we_total;
    do_start(64);
    for (int k = 0; k < 64; k++) send_word(k, WIDTH'(k), 0);
    wait_done(32'h7E0, "t4");
    check_val("t4_last_addr", {58'd0, imem_addr_out}, 64'd63);
    repeat (4) @(negedge clk);
    check_val("t4_we_count", 64'(we_total - we_mark), 64'd64);

    // Asynchronous reset in the middle of word 1.
    do_start(2);
    send_word(0, 32'h1122_3344, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2 rst = 1'b1;
    #1 check_all_zero("t5_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    we_mark = we_total;
    do_start(1);
    send_word(0, 32'hDEAD_BEEF, 0);
    wait_done(32'hDEAD_BEEF, "t5");
    check_val("t5_we_count", 64'(we_total - we_mark), 64'd1);

    // start and count changes during a load have no effect.
    we_mark = we_total;
    do_start(2);
    sb_q.push_back('{addr: INDEX'(0), data: 32'hCAFE_0102});
    send_byte(8'h02, 0);
    send_byte(8'h01, 0);
    start = 1'b1;
    word_count = (INDEX+1)'(5);
    @(negedge clk);
    start = 1'b0;
    send_byte(8'hFE, 0);
    send_byte(8'hCA, 0);
    check_val("t6_we_word0", {63'd0, imem_we_out}, 64'd1);
    send_word(1, 32'h0000_0001, 0);
    wait_done(32'hCAFE_0103, "t6");
    repeat (8) @(negedge clk);
    check_val("t6_we_count", 64'(we_total - we_mark), 64'd2);
    check_val("t6_still_idle", {63'd0, busy_out}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
